// File: rtl/regs_file.sv
// regs_file: X, Y and stack-pointer register slice on the special bus SB.
// Two internal phases (PHI1/PHI2) alternate every CLK; strobes act only in PHI1.
// Optional macro REGS_BUSERR_EN enables sticky control-conflict detection on BUS_ERR.

module regs_file (
   input  logic       CLK,
   input  logic       RES,
   input  logic       Y_SB,
   input  logic       X_SB,
   input  logic       S_SB,
   input  logic       SB_X,
   input  logic       SB_Y,
   input  logic       SB_S,
   input  logic       S_S,
   input  logic       S_ADL,
   input  logic [7:0] SB_IN,
   output logic [7:0] SB_OUT,
   output logic       SB_DRV,
   output logic [7:0] ADL_OUT,
   output logic       ADL_DRV,
   output logic       PHI1,
   output logic       PHI2,
   output logic       BUS_ERR
);

   localparam int unsigned W = 8;

   logic         ph_q;
   logic [W-1:0] x_q;
   logic [W-1:0] y_q;
   logic [W-1:0] sin_q;
   logic [W-1:0] sout_q;

   logic         phi1;
   logic [W-1:0] sb_mask;
   logic [W-1:0] sbv;

   assign phi1 = ~ph_q;
   assign PHI1 = phi1;
   assign PHI2 = ph_q;

   // Wired-AND of every selected register onto SB; all-ones when nothing drives.
   always_comb begin
      sb_mask = {W{1'b1}};
      SB_DRV  = 1'b0;
      if (phi1) begin
         SB_DRV = Y_SB | X_SB | S_SB;
         if (Y_SB) sb_mask = sb_mask & y_q;
         if (X_SB) sb_mask = sb_mask & x_q;
         if (S_SB) sb_mask = sb_mask & sout_q;
      end
   end

   assign SB_OUT = sb_mask;

   // Effective bus value seen by loads; uses pre-edge register state only.
   assign sbv = SB_IN & sb_mask;

   // Stack pointer onto ADL during PHI1 when requested.
   always_comb begin
      ADL_DRV = 1'b0;
      ADL_OUT = {W{1'b0}};
      if (phi1 && S_ADL) begin
         ADL_DRV = 1'b1;
         ADL_OUT = sout_q;
      end
   end

   // Phase toggle and register loads; PHI1 edge loads from SB, PHI2 edge moves SIN to SOUT.
   always_ff @(posedge CLK) begin
      if (RES) begin
         ph_q   <= 1'b0;
         x_q    <= {W{1'b0}};
         y_q    <= {W{1'b0}};
         sin_q  <= {W{1'b0}};
         sout_q <= {W{1'b0}};
      end else begin
         ph_q <= ~ph_q;
         if (phi1) begin
            if (SB_X) x_q <= sbv;
            if (SB_Y) y_q <= sbv;
            if (SB_S)     sin_q <= sbv;
            else if (S_S) sin_q <= sout_q;
         end else begin
            sout_q <= sin_q;
         end
      end
   end

`ifdef REGS_BUSERR_EN
   logic bus_err_q;
   logic conflict;

   // Two readers on SB at once, or SIN loaded from both SB and SOUT.
   assign conflict = phi1 & ((SB_S & S_S) |
                             (Y_SB & X_SB) | (Y_SB & S_SB) | (X_SB & S_SB));

   // Sticky conflict flag, cleared only by reset.
   always_ff @(posedge CLK) begin
      if (RES) bus_err_q <= 1'b0;
      else if (conflict) bus_err_q <= 1'b1;
   end

   assign BUS_ERR = bus_err_q;
`else
   assign BUS_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_regs_file.sv
// Self-checking bench for regs_file: directed vectors followed by random strobes,
// all checked against a register-level reference model.

module tb_regs_file;

   localparam logic [7:0] T_Y_SB  = 8'h80;
   localparam logic [7:0] T_X_SB  = 8'h40;
   localparam logic [7:0] T_S_SB  = 8'h20;
   localparam logic [7:0] T_SB_X  = 8'h10;
   localparam logic [7:0] T_SB_Y  = 8'h08;
   localparam logic [7:0] T_SB_S  = 8'h04;
   localparam logic [7:0] T_S_S   = 8'h02;
   localparam logic [7:0] T_S_ADL = 8'h01;

`ifdef REGS_BUSERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RES = 1'b0;
   logic       Y_SB = 1'b0, X_SB = 1'b0, S_SB = 1'b0;
   logic       SB_X = 1'b0, SB_Y = 1'b0, SB_S = 1'b0, S_S = 1'b0, S_ADL = 1'b0;
   logic [7:0] SB_IN = 8'hFF;
   logic [7:0] SB_OUT, ADL_OUT;
   logic       SB_DRV, ADL_DRV, PHI1, PHI2, BUS_ERR;

   int pass_cnt = 0;
   int total_cnt = 0;

   // reference state
   bit       m_ph;
   bit [7:0] m_x, m_y, m_sin, m_sout;
   bit       m_err;
   bit [7:0] cur_strb;
   bit [7:0] cur_sbin;
   bit       cur_res;

   regs_file dut (
      .CLK(CLK), .RES(RES),
      .Y_SB(Y_SB), .X_SB(X_SB), .S_SB(S_SB),
      .SB_X(SB_X), .SB_Y(SB_Y), .SB_S(SB_S), .S_S(S_S), .S_ADL(S_ADL),
      .SB_IN(SB_IN), .SB_OUT(SB_OUT), .SB_DRV(SB_DRV),
      .ADL_OUT(ADL_OUT), .ADL_DRV(ADL_DRV),
      .PHI1(PHI1), .PHI2(PHI2), .BUS_ERR(BUS_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic bit [7:0] exp_sb_out();
      bit [7:0] v = 8'hFF;
      if (!m_ph) begin
         if ((cur_strb & T_Y_SB) != 0) v = v & m_y;
         if ((cur_strb & T_X_SB) != 0) v = v & m_x;
         if ((cur_strb & T_S_SB) != 0) v = v & m_sout;
      end
      return v;
   endfunction

   // Apply inputs just after the edge, then wait for the mid-cycle sample point.
   task automatic drive(input bit [7:0] strb, input bit [7:0] sbin, input bit res);
      cur_strb = strb; cur_sbin = sbin; cur_res = res;
      {Y_SB, X_SB, S_SB, SB_X, SB_Y, SB_S, S_S, S_ADL} = strb;
      SB_IN = sbin;
      RES   = res;
      @(negedge CLK);
   endtask

   task automatic check_model();
      bit rd_any = !m_ph && ((cur_strb & (T_Y_SB | T_X_SB | T_S_SB)) != 0);
      bit adl    = !m_ph && ((cur_strb & T_S_ADL) != 0);
      check("sb_out",  SB_OUT,  exp_sb_out());
      check("sb_drv",  8'(SB_DRV), 8'(rd_any));
      check("adl_drv", 8'(ADL_DRV), 8'(adl));
      check("adl_out", ADL_OUT, adl ? m_sout : 8'h00);
      check("phi1",    8'(PHI1), 8'(!m_ph));
      check("phi2",    8'(PHI2), 8'(m_ph));
      check("bus_err", 8'(BUS_ERR), 8'(m_err));
   endtask

   // Advance through the edge and update the model from the same inputs.
   task automatic finish_cycle();
      bit [7:0] sbv;
      int       readers;
      @(posedge CLK);
      if (cur_res) begin
         m_ph = 1'b0; m_x = 8'h00; m_y = 8'h00; m_sin = 8'h00; m_sout = 8'h00; m_err = 1'b0;
      end else if (!m_ph) begin
         sbv = cur_sbin & exp_sb_out();
         readers = $countones(cur_strb & (T_Y_SB | T_X_SB | T_S_SB));
         if (ERR_EN && (readers >= 2 ||
             ((cur_strb & T_SB_S) != 0 && (cur_strb & T_S_S) != 0))) m_err = 1'b1;
         if ((cur_strb & T_SB_S) != 0)     m_sin = sbv;
         else if ((cur_strb & T_S_S) != 0) m_sin = m_sout;
         if ((cur_strb & T_SB_X) != 0) m_x = sbv;
         if ((cur_strb & T_SB_Y) != 0) m_y = sbv;
         m_ph = 1'b1;
      end else begin
         m_sout = m_sin;
         m_ph = 1'b0;
      end
      #1;
   endtask

   task automatic cycle(input bit [7:0] strb, input bit [7:0] sbin, input bit res);
      drive(strb, sbin, res);
      check_model();
      finish_cycle();
   endtask

   initial begin
      bit [7:0] strb;
      // model starts unknown; reset first so both agree
      m_ph = 1'b0; m_x = 8'h00; m_y = 8'h00; m_sin = 8'h00; m_sout = 8'h00; m_err = 1'b0;
      @(posedge CLK); #1;
      drive(8'h00, 8'hFF, 1'b1);
      finish_cycle();

      // reset state
      drive(8'h00, 8'hFF, 1'b0);
      check_model();
      check("rst_sb_out", SB_OUT, 8'hFF);
      check("rst_phi1", 8'(PHI1), 8'h01);
      check("rst_adl_out", ADL_OUT, 8'h00);
      finish_cycle();
      cycle(8'h00, 8'hFF, 1'b0);

      // load X then read it back
      cycle(T_SB_X, 8'h5A, 1'b0);
      cycle(8'h00, 8'hFF, 1'b0);
      drive(T_X_SB, 8'hFF, 1'b0);
      check_model();
      check("x_read", SB_OUT, 8'h5A);
      check("x_drv", 8'(SB_DRV), 8'h01);
      finish_cycle();
      cycle(8'h00, 8'hFF, 1'b0);

      // X -> Y transfer in one PHI1
      cycle(T_SB_X, 8'h3C, 1'b0);
      cycle(8'h00, 8'hFF, 1'b0);
      cycle(T_X_SB | T_SB_Y, 8'hFF, 1'b0);
      cycle(8'h00, 8'hFF, 1'b0);
      drive(T_Y_SB, 8'hFF, 1'b0);
      check_model();
      check("y_from_x", SB_OUT, 8'h3C);
      finish_cycle();
      cycle(8'h00, 8'hFF, 1'b0);
      drive(T_X_SB, 8'hFF, 1'b0);
      check_model();
      check("x_kept", SB_OUT, 8'h3C);
      check("no_err", 8'(BUS_ERR), 8'h00);
      finish_cycle();
      cycle(8'h00, 8'hFF, 1'b0);

      // stack pointer load, latency and recirculation
      cycle(T_SB_S, 8'hFD, 1'b0);
      cycle(8'h00, 8'hFF, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(T_S_ADL | T_S_S, 8'hFF, 1'b0);
         check_model();
         check("s_adl", ADL_OUT, 8'hFD);
         check("s_adl_drv", 8'(ADL_DRV), 8'h01);
         finish_cycle();
         cycle(8'h00, 8'hFF, 1'b0);
      end

      // strobe in PHI2 ignored
      cycle(8'h00, 8'hFF, 1'b0);
      cycle(T_SB_X, 8'h11, 1'b0);
      drive(T_X_SB, 8'hFF, 1'b0);
      check_model();
      check("phi2_ignored", SB_OUT, 8'h3C);
      finish_cycle();
      cycle(8'h00, 8'hFF, 1'b0);

      // reset beats a coincident load
      cycle(T_SB_Y, 8'h77, 1'b1);
      drive(T_Y_SB, 8'hFF, 1'b0);
      check_model();
      check("res_y", SB_OUT, 8'h00);
      check("res_phi1", 8'(PHI1), 8'h01);
      finish_cycle();
      cycle(8'h00, 8'hFF, 1'b0);

      // double reader conflict
      cycle(T_SB_X, 8'hF0, 1'b0);
      cycle(8'h00, 8'hFF, 1'b0);
      cycle(T_SB_Y, 8'h3C, 1'b0);
      cycle(8'h00, 8'hFF, 1'b0);
      drive(T_X_SB | T_Y_SB, 8'hFF, 1'b0);
      check_model();
      check("and_read", SB_OUT, 8'h30);
      finish_cycle();
      for (int i = 0; i < 4; i++) begin
         drive(8'h00, 8'hFF, 1'b0);
         check_model();
         check("err_sticky", 8'(BUS_ERR), ERR_EN ? 8'h01 : 8'h00);
         finish_cycle();
      end
      cycle(8'h00, 8'hFF, 1'b1);
      drive(8'h00, 8'hFF, 1'b0);
      check_model();
      check("err_cleared", 8'(BUS_ERR), 8'h00);
      finish_cycle();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         strb = 8'h00;
         for (int b = 0; b < 8; b++)
            if ($urandom_range(0, 3) == 0) strb[b] = 1'b1;
         cycle(strb,
               ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom),
               $urandom_range(0, 49) == 0);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/regs_file.md
REGS_FILE -- requirements
Module: regs_file

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 SHALL have port RES, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have inputs Y_SB, X_SB, S_SB, SB_X, SB_Y, SB_S, S_S, S_ADL, 1 bit each: register-bus control strobes, active-high.
REQ-004 SHALL have port SB_IN, input, 8 bits: value placed on special bus SB by all other drivers; 8'hFF when undriven.
REQ-005 SHALL have port SB_OUT, output, 8 bits: this block's contribution to SB.
REQ-006 SHALL have port SB_DRV, output, 1 bit: high when this block drives SB.
REQ-007 SHALL have port ADL_OUT, output, 8 bits: stack pointer onto address bus low.
REQ-008 SHALL have port ADL_DRV, output, 1 bit: high when ADL_OUT is valid.
REQ-009 SHALL have ports PHI1 and PHI2, outputs, 1 bit each: internal phase indicators.
REQ-010 SHALL have port BUS_ERR, output, 1 bit: sticky control-conflict flag.

Function
REQ-011 SHALL hold phase flop PH; PHI1 = ~PH, PHI2 = PH; PH toggles every CLK; a PHI1 cycle is always followed by a PHI2 cycle.
REQ-012 SHALL hold 8-bit registers X, Y, S input latch SIN, S output latch SOUT.
REQ-013 SHALL honour strobes only in PHI1 cycles; all strobes ignored in PHI2 cycles.
REQ-014 During PHI1: SB_DRV = Y_SB | X_SB | S_SB; SB_OUT = AND of Y (if Y_SB), X (if X_SB), SOUT (if S_SB); SB_OUT = 8'hFF when none selected; combinational, zero latency.
REQ-015 During PHI2: SB_DRV = 0, SB_OUT = 8'hFF.
REQ-016 Effective bus value SBV = SB_IN & SB_OUT (wired-AND, NMOS-style).
REQ-017 On the CLK edge ending a PHI1 cycle: SB_X -> X <= SBV; SB_Y -> Y <= SBV; SB_S -> SIN <= SBV; else S_S -> SIN <= SOUT; else SIN holds.
REQ-018 Same-phase read and write of one register (e.g. X_SB & SB_X) SHALL load the pre-edge value ANDed with SB_IN; no combinational loop through state.
REQ-019 On the CLK edge ending a PHI2 cycle: SOUT <= SIN; X, Y unchanged.
REQ-020 ADL_DRV = S_ADL during PHI1, 0 during PHI2; ADL_OUT = SOUT whenever ADL_DRV, else 8'h00.
REQ-021 Transfer X->Y in one PHI1 cycle: X_SB & SB_Y with SB_IN = 8'hFF SHALL load Y with X; SOUT visible to S_SB/S_ADL only after the following PHI2 edge (one full PH pair latency from SB_S).
REQ-022 Conflicts raising BUS_ERR (PHI1 only): SB_S & S_S; two or more of Y_SB, X_SB, S_SB; BUS_ERR rises on the edge ending that cycle and stays high until RES.

Reset
REQ-023 RES sampled high SHALL set PH=0, X=Y=SIN=SOUT=8'h00, BUS_ERR=0 at the next edge.
REQ-024 RES SHALL take priority over all loads in the same cycle; a strobe coincident with RES has no effect.
REQ-025 First cycle after RES deasserts SHALL be a PHI1 cycle.
REQ-026 Outputs after reset: SB_OUT=8'hFF, SB_DRV=0, ADL_OUT=8'h00, ADL_DRV=0, PHI1=1, PHI2=0, BUS_ERR=0 (all with strobes low).

Configuration
REQ-027 Macro REGS_BUSERR_EN: defined -> conflict detection per REQ-022 present; undefined -> detection logic omitted, BUS_ERR tied 0; all other behaviour identical.

Verification
REQ-028 RES 1 cycle; PHI1: SB_X, SB_IN=8'h5A -> after edge X=8'h5A; next PHI1 X_SB -> SB_OUT=8'h5A, SB_DRV=1.
REQ-029 X=8'h3C; PHI1: X_SB & SB_Y, SB_IN=8'hFF -> Y=8'h3C, X unchanged, BUS_ERR=0.
REQ-030 PHI1: SB_S, SB_IN=8'hFD -> PHI2 edge -> next PHI1 S_ADL gives ADL_OUT=8'hFD, ADL_DRV=1; S_S for 4 phase pairs keeps 8'hFD.
REQ-031 X=8'hF0, Y=8'h3C; PHI1: X_SB & Y_SB -> SB_OUT=8'h30; with REGS_BUSERR_EN BUS_ERR=1 after edge and stays 1 until RES; without it BUS_ERR=0.
REQ-032 Strobe SB_X asserted only in PHI2 cycle with SB_IN=8'h11 -> X unchanged; RES asserted with SB_Y in PHI1 -> Y=8'h00, PH=0.
